param_bus_datapath: RTL and testbench
=====================================

Name: param_bus_datapath

Overview:
- Parametrised successor to the single-bus CPU datapath.
- Contains a register file of NREGS×WIDTH; PC, IR, MAR, MDR, HI, LO, Y, 2×WIDTH Z, InPort and OutPort, all on one internal bus.
- Bus source is chosen by an encoded select, not one-hot out-enables.
- ALU does single-cycle ops plus iterative signed multiply/divide with a busy/done handshake; the control unit sequences everything.

Parameters:
- WIDTH, 32, data/bus width (≥8)
- NREGS, 16, number of general registers (power of 2); SELW = clog2(NREGS)

Ports:
- clk  in  1  clock, all state rising-edge
- clr  in  1  reset, asynchronous, active-low
- bus_src  in  4  bus driver: 0 reg[rd_sel], 1 HI, 2 LO, 3 ZHI, 4 ZLO, 5 PC, 6 MDR, 7 InPort, 8 imm
- rd_sel  in  SELW  register driven when bus_src=0
- wr_sel  in  SELW  register written when rf_wr=1
- rf_wr  in  1  write bus into reg[wr_sel]
- y_in, hi_in, lo_in, ir_in, mar_in, outport_in  in  1 each  load the named register from bus
- pc_in  in  1  PC ← bus
- pc_inc  in  1  PC ← PC+1
- mdr_in  in  1  load MDR
- mdr_read  in  1  MDR source: 1 mem_data_in, 0 bus
- z_in  in  1  load Z from single-cycle ALU result
- alu_op  in  4  0 ADD,1 SUB,2 AND,3 OR,4 SHR,5 SHRA,6 SHL,7 ROR,8 ROL,9 NEG,10 NOT,11 MUL,12 DIV,13 PASS_B; others → result 0
- alu_start  in  1  begin MUL/DIV
- mem_data_in  in  WIDTH  memory read data
- inport_data  in  WIDTH  external input, sampled into InPort every cycle
- imm  in  WIDTH  sign-extended constant
- bus  out  WIDTH  current bus value
- pc, ir, mar, mdr, hi, lo, outport  out  WIDTH  register contents
- zhi, zlo  out  WIDTH  Z halves
- alu_busy  out  1  iterative op in progress
- alu_done  out  1  one-cycle pulse: MUL/DIV result now in Z
- div_zero  out  1  last DIV had divisor 0

Behaviour:
- Reset: clr low asynchronously clears every register, Z, InPort, the FSM, alu_busy, alu_done and div_zero to 0. Reset mid-operation aborts; Z is not written.
- Bus: purely combinational mux from bus_src. Codes 9–15 drive 0. There is never more than one driver.
- Register loads: each load occurs on the clock edge when its enable is high. Any number of enables may be high in the same cycle. Operands are A = Y and B = bus.
- PC: pc_in has priority over pc_inc. PC+1 wraps modulo 2^WIDTH.
- Single-cycle ops (z_in=1, op ≠ MUL/DIV):
  - ZLO ← result and ZHI ← 0 at the next edge.
  - Shift and rotate amount = B[clog2(WIDTH)-1:0]. SHRA is arithmetic.
  - NEG = −B and NOT = ~B.
  - ADD/SUB wrap.
- Iterative FSM states: IDLE → RUN → IDLE.
  - In IDLE, alu_start=1 with op MUL or DIV captures A and B at edge 0. State goes to RUN, alu_busy=1, counter=0.
  - RUN performs one step per edge for WIDTH edges (edges 1..WIDTH).
  - At edge WIDTH: Z written, alu_busy→0, alu_done=1 for exactly one cycle, back to IDLE.
  - Result is visible WIDTH cycles after the start edge.
- MUL: signed A×B, 2·WIDTH product; ZHI = upper half, ZLO = lower half.
- DIV: signed truncating division of A by B.
  - ZLO = quotient; ZHI = remainder, whose sign follows the dividend.
  - Most-negative ÷ −1: ZLO = most-negative, ZHI = 0.
  - B = 0: same latency; ZLO = all ones, ZHI = A, div_zero=1.
  - div_zero is cleared on the next accepted alu_start.
- While alu_busy:
  - alu_start and z_in are ignored; Z is owned by the FSM.
  - The other register loads and the bus operate normally.
- alu_start with a non-MUL/DIV op is ignored.
- alu_start and z_in together in IDLE with op MUL/DIV: start wins and z_in is ignored.

Test Plan (WIDTH=32, NREGS=16):
- Reset during RUN of MUL, at cycle 10 → next cycle: alu_busy=0, zhi=zlo=0, all registers 0; no alu_done pulse.
- Register and bus path:
  - imm=0x0000_00A5, bus_src=8, rf_wr=1, wr_sel=3 → reg3=0xA5.
  - Then bus_src=0, rd_sel=3 → bus=0xA5.
  - Same cycle, pc_in=1 and pc_inc=1 → pc=0xA5.
- Single-cycle ADD with wrap: Y=0xFFFF_FFFF, B=2, ADD, z_in → zlo=1, zhi=0. Then ROR with Y=0x8000_0001, B=1 → zlo=0xC000_0000.
- MUL: Y=−3 (0xFFFF_FFFD), B=7, alu_start at edge 0:
  - alu_busy high for cycles 1–32.
  - alu_done high only in the cycle after edge 32.
  - {zhi,zlo} = 0xFFFF_FFFF_FFFF_FFEB.
  - alu_start pulsed at cycle 5 during the run has no effect.
- DIV sign cases and divide-by-zero:
  - −7 ÷ 2 → zlo=0xFFFF_FFFD, zhi=0xFFFF_FFFF.
  - 0x8000_0000 ÷ −1 → zlo=0x8000_0000, zhi=0.
  - 9 ÷ 0 → zlo=0xFFFF_FFFF, zhi=9, div_zero=1; the next start clears it.
- MDR source select:
  - mem_data_in=0x1234_5678, mdr_read=1, mdr_in=1 → mdr=0x1234_5678.
  - bus_src=6, outport_in=1 → outport=0x1234_5678.

Source files
------------

// File: rtl/param_bus_datapath_if.sv
// Control and observation bundle for the parameterised single-bus datapath.
// The sequencer drives through master; the datapath attaches through slave.
interface param_bus_datapath_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned NREGS = 16
) ();
   localparam int unsigned SELW = $clog2(NREGS);

   logic [3:0]       bus_src;
   logic [SELW-1:0]  rd_sel;
   logic [SELW-1:0]  wr_sel;
   logic             rf_wr;
   logic             y_in;
   logic             hi_in;
   logic             lo_in;
   logic             ir_in;
   logic             mar_in;
   logic             outport_in;
   logic             pc_in;
   logic             pc_inc;
   logic             mdr_in;
   logic             mdr_read;
   logic             z_in;
   logic [3:0]       alu_op;
   logic             alu_start;
   logic [WIDTH-1:0] mem_data_in;
   logic [WIDTH-1:0] inport_data;
   logic [WIDTH-1:0] imm;

   logic [WIDTH-1:0] bus;
   logic [WIDTH-1:0] pc;
   logic [WIDTH-1:0] ir;
   logic [WIDTH-1:0] mar;
   logic [WIDTH-1:0] mdr;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic [WIDTH-1:0] outport;
   logic [WIDTH-1:0] zhi;
   logic [WIDTH-1:0] zlo;
   logic             alu_busy;
   logic             alu_done;
   logic             div_zero;

   modport master (
      output bus_src, rd_sel, wr_sel, rf_wr, y_in, hi_in, lo_in, ir_in, mar_in,
             outport_in, pc_in, pc_inc, mdr_in, mdr_read, z_in, alu_op, alu_start,
             mem_data_in, inport_data, imm,
      input  bus, pc, ir, mar, mdr, hi, lo, outport, zhi, zlo,
             alu_busy, alu_done, div_zero
   );

   modport slave (
      input  bus_src, rd_sel, wr_sel, rf_wr, y_in, hi_in, lo_in, ir_in, mar_in,
             outport_in, pc_in, pc_inc, mdr_in, mdr_read, z_in, alu_op, alu_start,
             mem_data_in, inport_data, imm,
      output bus, pc, ir, mar, mdr, hi, lo, outport, zhi, zlo,
             alu_busy, alu_done, div_zero
   );
endinterface

// File: rtl/param_bus_datapath.sv
// Single-bus CPU datapath: register file, special registers, encoded bus mux,
// single-cycle ALU and an iterative signed multiply/divide unit.
module param_bus_datapath #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned NREGS = 16
) (
   input  logic                   clk,
   input  logic                   clr,
   param_bus_datapath_if.slave    bus_if
);
   localparam int unsigned SHW = $clog2(WIDTH);
   localparam int unsigned CW  = $clog2(WIDTH);

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR   = 4'd3,
      OP_SHR  = 4'd4,  OP_SHRA = 4'd5,  OP_SHL  = 4'd6,  OP_ROR  = 4'd7,
      OP_ROL  = 4'd8,  OP_NEG  = 4'd9,  OP_NOT  = 4'd10, OP_MUL  = 4'd11,
      OP_DIV  = 4'd12, OP_PASS = 4'd13, OP_R14  = 4'd14, OP_R15  = 4'd15
   } alu_op_e;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_e;

   logic [WIDTH-1:0] rf_q [NREGS];
   logic [WIDTH-1:0] rf_d [NREGS];
   logic [WIDTH-1:0] pc_q, pc_d, ir_q, ir_d, mar_q, mar_d, mdr_q, mdr_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, y_q, y_d;
   logic [WIDTH-1:0] zhi_q, zhi_d, zlo_q, zlo_d;
   logic [WIDTH-1:0] inport_q, inport_d, outport_q, outport_d;

   state_e           state_q, state_d;
   logic             busy_q, busy_d, done_q, done_d, dz_q, dz_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             is_div_q, is_div_d, neg_q, neg_d, neg_rem_q, neg_rem_d;
   logic             bzero_q, bzero_d;
   logic [WIDTH-1:0] a_q, a_d, bmag_q, bmag_d, acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;

   logic [WIDTH-1:0]   bus_c;
   alu_op_e            op_c;
   logic [SHW-1:0]     shamt_c;
   logic [WIDTH-1:0]   alu_res_c;
   logic [WIDTH-1:0]   a_mag_c, b_mag_c;
   logic               start_ok_c;
   logic [WIDTH:0]     mul_sum_c, rem_sh_c;
   logic               div_ge_c;
   logic [WIDTH-1:0]   step_hi_c, step_lo_c;
   logic [2*WIDTH-1:0] prod_c;
   logic [WIDTH-1:0]   fin_hi_c, fin_lo_c;

   assign op_c    = alu_op_e'(bus_if.alu_op);
   assign shamt_c = bus_c[SHW-1:0];

   // Encoded bus source; unused codes drive zero
   always_comb begin : bus_mux
      bus_c = '0;
      case (bus_if.bus_src)
         4'd0:    bus_c = rf_q[bus_if.rd_sel];
         4'd1:    bus_c = hi_q;
         4'd2:    bus_c = lo_q;
         4'd3:    bus_c = zhi_q;
         4'd4:    bus_c = zlo_q;
         4'd5:    bus_c = pc_q;
         4'd6:    bus_c = mdr_q;
         4'd7:    bus_c = inport_q;
         4'd8:    bus_c = bus_if.imm;
         default: bus_c = '0;
      endcase
   end

   // Single-cycle ALU: A is Y, B is the bus
   always_comb begin : single_alu
      alu_res_c = '0;
      case (op_c)
         OP_ADD:  alu_res_c = y_q + bus_c;
         OP_SUB:  alu_res_c = y_q - bus_c;
         OP_AND:  alu_res_c = y_q & bus_c;
         OP_OR:   alu_res_c = y_q | bus_c;
         OP_SHR:  alu_res_c = y_q >> shamt_c;
         OP_SHRA: alu_res_c = $unsigned($signed(y_q) >>> shamt_c);
         OP_SHL:  alu_res_c = y_q << shamt_c;
         OP_ROR:  alu_res_c = WIDTH'({y_q, y_q} >> shamt_c);
         OP_ROL:  alu_res_c = WIDTH'(({y_q, y_q} << shamt_c) >> WIDTH);
         OP_NEG:  alu_res_c = '0 - bus_c;
         OP_NOT:  alu_res_c = ~bus_c;
         OP_PASS: alu_res_c = bus_c;
         default: alu_res_c = '0;
      endcase
   end

   assign a_mag_c    = y_q[WIDTH-1]   ? ('0 - y_q)   : y_q;
   assign b_mag_c    = bus_c[WIDTH-1] ? ('0 - bus_c) : bus_c;
   assign start_ok_c = bus_if.alu_start && (op_c == OP_MUL || op_c == OP_DIV);

   // One iteration on magnitudes: shift-add multiply or restoring divide
   always_comb begin : iter_step
      mul_sum_c = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, bmag_q} : '0);
      rem_sh_c  = {acc_hi_q, acc_lo_q[WIDTH-1]};
      div_ge_c  = rem_sh_c >= {1'b0, bmag_q};
      if (is_div_q) begin
         step_hi_c = div_ge_c ? WIDTH'(rem_sh_c - {1'b0, bmag_q}) : WIDTH'(rem_sh_c);
         step_lo_c = {acc_lo_q[WIDTH-2:0], div_ge_c};
      end else begin
         step_hi_c = mul_sum_c[WIDTH:1];
         step_lo_c = {mul_sum_c[0], acc_lo_q[WIDTH-1:1]};
      end
   end

   // Sign fix-up of the final iteration; divide-by-zero overrides the quotient
   always_comb begin : finish_fix
      prod_c   = {step_hi_c, step_lo_c};
      fin_hi_c = '0;
      fin_lo_c = '0;
      if (is_div_q) begin
         if (bzero_q) begin
            fin_lo_c = '1;
            fin_hi_c = a_q;
         end else begin
            fin_lo_c = neg_q     ? ('0 - step_lo_c) : step_lo_c;
            fin_hi_c = neg_rem_q ? ('0 - step_hi_c) : step_hi_c;
         end
      end else begin
         if (neg_q) prod_c = '0 - prod_c;
         fin_hi_c = prod_c[2*WIDTH-1:WIDTH];
         fin_lo_c = prod_c[WIDTH-1:0];
      end
   end

   always_comb begin : next_state
      rf_d       = rf_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      mar_d      = mar_q;
      mdr_d      = mdr_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      y_d        = y_q;
      zhi_d      = zhi_q;
      zlo_d      = zlo_q;
      outport_d  = outport_q;
      inport_d   = bus_if.inport_data;
      state_d    = state_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      dz_d       = dz_q;
      cnt_d      = cnt_q;
      is_div_d   = is_div_q;
      neg_d      = neg_q;
      neg_rem_d  = neg_rem_q;
      bzero_d    = bzero_q;
      a_d        = a_q;
      bmag_d     = bmag_q;
      acc_hi_d   = acc_hi_q;
      acc_lo_d   = acc_lo_q;

      if (bus_if.rf_wr)      rf_d[bus_if.wr_sel] = bus_c;
      if (bus_if.y_in)       y_d       = bus_c;
      if (bus_if.hi_in)      hi_d      = bus_c;
      if (bus_if.lo_in)      lo_d      = bus_c;
      if (bus_if.ir_in)      ir_d      = bus_c;
      if (bus_if.mar_in)     mar_d     = bus_c;
      if (bus_if.outport_in) outport_d = bus_c;
      if (bus_if.mdr_in)     mdr_d     = bus_if.mdr_read ? bus_if.mem_data_in : bus_c;
      if (bus_if.pc_in)       pc_d = bus_c;
      else if (bus_if.pc_inc) pc_d = pc_q + WIDTH'(1);

      if (state_q == S_IDLE) begin
         if (start_ok_c) begin
            state_d   = S_RUN;
            busy_d    = 1'b1;
            dz_d      = 1'b0;
            cnt_d     = '0;
            is_div_d  = (op_c == OP_DIV);
            neg_d     = y_q[WIDTH-1] ^ bus_c[WIDTH-1];
            neg_rem_d = y_q[WIDTH-1];
            bzero_d   = (bus_c == '0);
            a_d       = y_q;
            bmag_d    = b_mag_c;
            acc_hi_d  = '0;
            acc_lo_d  = a_mag_c;
         end else if (bus_if.z_in) begin
            zlo_d = alu_res_c;
            zhi_d = '0;
         end
      end else begin
         acc_hi_d = step_hi_c;
         acc_lo_d = step_lo_c;
         cnt_d    = cnt_q + CW'(1);
         if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            dz_d    = is_div_q & bzero_q;
            zhi_d   = fin_hi_c;
            zlo_d   = fin_lo_c;
         end
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         for (int i = 0; i < int'(NREGS); i++) rf_q[i] <= '0;
         pc_q      <= '0;
         ir_q      <= '0;
         mar_q     <= '0;
         mdr_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         y_q       <= '0;
         zhi_q     <= '0;
         zlo_q     <= '0;
         inport_q  <= '0;
         outport_q <= '0;
         state_q   <= S_IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         dz_q      <= 1'b0;
         cnt_q     <= '0;
         is_div_q  <= 1'b0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         bzero_q   <= 1'b0;
         a_q       <= '0;
         bmag_q    <= '0;
         acc_hi_q  <= '0;
         acc_lo_q  <= '0;
      end else begin
         rf_q      <= rf_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         mar_q     <= mar_d;
         mdr_q     <= mdr_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         y_q       <= y_d;
         zhi_q     <= zhi_d;
         zlo_q     <= zlo_d;
         inport_q  <= inport_d;
         outport_q <= outport_d;
         state_q   <= state_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         dz_q      <= dz_d;
         cnt_q     <= cnt_d;
         is_div_q  <= is_div_d;
         neg_q     <= neg_d;
         neg_rem_q <= neg_rem_d;
         bzero_q   <= bzero_d;
         a_q       <= a_d;
         bmag_q    <= bmag_d;
         acc_hi_q  <= acc_hi_d;
         acc_lo_q  <= acc_lo_d;
      end
   end

   assign bus_if.bus      = bus_c;
   assign bus_if.pc       = pc_q;
   assign bus_if.ir       = ir_q;
   assign bus_if.mar      = mar_q;
   assign bus_if.mdr      = mdr_q;
   assign bus_if.hi       = hi_q;
   assign bus_if.lo       = lo_q;
   assign bus_if.outport  = outport_q;
   assign bus_if.zhi      = zhi_q;
   assign bus_if.zlo      = zlo_q;
   assign bus_if.alu_busy = busy_q;
   assign bus_if.alu_done = done_q;
   assign bus_if.div_zero = dz_q;
endmodule

// File: tb/tb_param_bus_datapath.sv
// Randomised bench for param_bus_datapath against a behavioural model using
// native signed arithmetic, plus directed literal checks.
module tb_param_bus_datapath;
   localparam int unsigned W = 32;
   localparam int unsigned N = 16;

   logic clk = 1'b0;
   logic clr = 1'b0;
   always #5 clk = ~clk;

   param_bus_datapath_if #(.WIDTH(W), .NREGS(N)) dif ();
   param_bus_datapath #(.WIDTH(W), .NREGS(N)) dut (.clk(clk), .clr(clr), .bus_if(dif));

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   // Behavioural model state
   logic [W-1:0] m_rf [N];
   logic [W-1:0] m_pc, m_ir, m_mar, m_mdr, m_hi, m_lo, m_y, m_zhi, m_zlo, m_in, m_out;
   logic [W-1:0] m_phi, m_plo;
   bit           m_busy, m_done, m_dz, m_pdz;
   int           m_cnt;

   task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] exp_bus();
      case (dif.bus_src)
         4'd0: return m_rf[dif.rd_sel];
         4'd1: return m_hi;
         4'd2: return m_lo;
         4'd3: return m_zhi;
         4'd4: return m_zlo;
         4'd5: return m_pc;
         4'd6: return m_mdr;
         4'd7: return m_in;
         4'd8: return dif.imm;
         default: return '0;
      endcase
   endfunction

   function automatic logic [W-1:0] single_op(input logic [3:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
      int sh;
      logic [W-1:0] r;
      sh = int'(b[4:0]);
      r  = a;
      case (op)
         4'd0:  return a + b;
         4'd1:  return a - b;
         4'd2:  return a & b;
         4'd3:  return a | b;
         4'd4:  return a >> sh;
         4'd5:  return $unsigned($signed(a) >>> sh);
         4'd6:  return a << sh;
         4'd7:  begin repeat (sh) r = {r[0], r[W-1:1]}; return r; end
         4'd8:  begin repeat (sh) r = {r[W-2:0], r[W-1]}; return r; end
         4'd9:  return -b;
         4'd10: return ~b;
         4'd13: return b;
         default: return '0;
      endcase
   endfunction

   task automatic long_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] hi, output logic [W-1:0] lo, output bit dz);
      longint pa, pb;
      logic [63:0] p;
      pa = longint'($signed(a));
      pb = longint'($signed(b));
      dz = 1'b0;
      if (op == 4'd11) begin
         p  = 64'(pa * pb);
         hi = p[63:32];
         lo = p[31:0];
      end else if (b == '0) begin
         lo = '1;
         hi = a;
         dz = 1'b1;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         lo = a;
         hi = '0;
      end else begin
         lo = W'(pa / pb);
         hi = W'(pa % pb);
      end
   endtask

   always @(posedge clk or negedge clr) begin
      if (!clr) begin
         for (int i = 0; i < int'(N); i++) m_rf[i] = '0;
         {m_pc, m_ir, m_mar, m_mdr, m_hi, m_lo, m_y, m_zhi, m_zlo, m_in, m_out} = '0;
         m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0; m_cnt = 0;
      end else begin
         logic [W-1:0] b, a;
         b = exp_bus();
         a = m_y;
         m_done = 1'b0;
         if (m_busy) begin
            m_cnt++;
            if (m_cnt == int'(W)) begin
               m_zhi = m_phi; m_zlo = m_plo; m_dz = m_pdz;
               m_busy = 1'b0; m_done = 1'b1;
            end
         end else if (dif.alu_start && (dif.alu_op == 4'd11 || dif.alu_op == 4'd12)) begin
            long_op(dif.alu_op, a, b, m_phi, m_plo, m_pdz);
            m_busy = 1'b1; m_cnt = 0; m_dz = 1'b0;
         end else if (dif.z_in) begin
            m_zlo = single_op(dif.alu_op, a, b);
            m_zhi = '0;
         end
         if (dif.rf_wr)      m_rf[dif.wr_sel] = b;
         if (dif.y_in)       m_y   = b;
         if (dif.hi_in)      m_hi  = b;
         if (dif.lo_in)      m_lo  = b;
         if (dif.ir_in)      m_ir  = b;
         if (dif.mar_in)     m_mar = b;
         if (dif.outport_in) m_out = b;
         if (dif.mdr_in)     m_mdr = dif.mdr_read ? dif.mem_data_in : b;
         if (dif.pc_in)       m_pc = b;
         else if (dif.pc_inc) m_pc = m_pc + 1;
         m_in = dif.inport_data;
      end
   end

   // Per-cycle comparison of every output against the model
   always @(negedge clk) begin
      if (chk_en) begin
         cmp("bus", dif.bus, exp_bus());
         cmp("pc", dif.pc, m_pc);
         cmp("ir", dif.ir, m_ir);
         cmp("mar", dif.mar, m_mar);
         cmp("mdr", dif.mdr, m_mdr);
         cmp("hi", dif.hi, m_hi);
         cmp("lo", dif.lo, m_lo);
         cmp("outport", dif.outport, m_out);
         cmp("zhi", dif.zhi, m_zhi);
         cmp("zlo", dif.zlo, m_zlo);
         cmp("alu_busy", W'(dif.alu_busy), W'(m_busy));
         cmp("alu_done", W'(dif.alu_done), W'(m_done));
         cmp("div_zero", W'(dif.div_zero), W'(m_dz));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ctl();
      dif.bus_src = '0; dif.rd_sel = '0; dif.wr_sel = '0; dif.rf_wr = 1'b0;
      dif.y_in = 1'b0; dif.hi_in = 1'b0; dif.lo_in = 1'b0; dif.ir_in = 1'b0;
      dif.mar_in = 1'b0; dif.outport_in = 1'b0; dif.pc_in = 1'b0; dif.pc_inc = 1'b0;
      dif.mdr_in = 1'b0; dif.mdr_read = 1'b0; dif.z_in = 1'b0; dif.alu_op = '0;
      dif.alu_start = 1'b0; dif.mem_data_in = '0; dif.inport_data = '0; dif.imm = '0;
   endtask

   task automatic load_y(input logic [W-1:0] v);
      dif.bus_src = 4'd8; dif.imm = v; dif.y_in = 1'b1;
      tick();
      dif.y_in = 1'b0;
   endtask

   task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_lo, input logic [W-1:0] exp_hi,
                          input logic exp_dz);
      load_y(a);
      dif.imm = b; dif.alu_op = 4'd12; dif.alu_start = 1'b1;
      tick();
      dif.alu_start = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (dif.alu_done) break;
         tick();
      end
      cmp("div_done", W'(dif.alu_done), W'(1));
      cmp("div_zlo", dif.zlo, exp_lo);
      cmp("div_zhi", dif.zhi, exp_hi);
      cmp("div_zero_flag", W'(dif.div_zero), W'(exp_dz));
   endtask

   initial begin
      clear_ctl();
      clr = 1'b0;
      tick(); tick();
      chk_en = 1'b1;
      cmp("rst_pc", dif.pc, '0);
      cmp("rst_zlo", dif.zlo, '0);
      cmp("rst_busy", W'(dif.alu_busy), '0);
      clr = 1'b1;
      tick();

      // Register file write then read, PC load priority
      dif.imm = 32'h0000_00A5; dif.bus_src = 4'd8; dif.rf_wr = 1'b1; dif.wr_sel = 4'd3;
      tick();
      dif.rf_wr = 1'b0; dif.bus_src = 4'd0; dif.rd_sel = 4'd3; dif.imm = '0;
      dif.pc_in = 1'b1; dif.pc_inc = 1'b1;
      #1;
      cmp("reg3_bus", dif.bus, 32'h0000_00A5);
      tick();
      dif.pc_in = 1'b0; dif.pc_inc = 1'b0;
      cmp("pc_load", dif.pc, 32'h0000_00A5);

      // Single-cycle ADD wrap and ROR
      load_y(32'hFFFF_FFFF);
      dif.imm = 32'd2; dif.alu_op = 4'd0; dif.z_in = 1'b1;
      tick();
      dif.z_in = 1'b0;
      cmp("add_zlo", dif.zlo, 32'd1);
      cmp("add_zhi", dif.zhi, 32'd0);
      load_y(32'h8000_0001);
      dif.imm = 32'd1; dif.alu_op = 4'd7; dif.z_in = 1'b1;
      tick();
      dif.z_in = 1'b0;
      cmp("ror_zlo", dif.zlo, 32'hC000_0000);

      // Signed MUL with a stray start mid-run
      load_y(32'hFFFF_FFFD);
      dif.imm = 32'd7; dif.alu_op = 4'd11; dif.alu_start = 1'b1;
      tick();
      dif.alu_start = 1'b0;
      for (int c = 1; c <= 32; c++) begin
         cmp("mul_busy", W'(dif.alu_busy), W'(1));
         cmp("mul_nodone", W'(dif.alu_done), W'(0));
         if (c == 5) begin dif.alu_start = 1'b1; dif.alu_op = 4'd12; end
         tick();
         dif.alu_start = 1'b0; dif.alu_op = 4'd11;
      end
      cmp("mul_idle", W'(dif.alu_busy), W'(0));
      cmp("mul_done", W'(dif.alu_done), W'(1));
      cmp("mul_zhi", dif.zhi, 32'hFFFF_FFFF);
      cmp("mul_zlo", dif.zlo, 32'hFFFF_FFEB);
      tick();
      cmp("mul_done_pulse", W'(dif.alu_done), W'(0));

      // DIV sign cases and divide by zero
      run_div(32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
      run_div(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
      run_div(32'd9, 32'd0, 32'hFFFF_FFFF, 32'd9, 1'b1);
      tick();
      cmp("dz_held", W'(dif.div_zero), W'(1));
      dif.imm = 32'd3; dif.alu_op = 4'd11; dif.alu_start = 1'b1;
      tick();
      dif.alu_start = 1'b0;
      cmp("dz_cleared", W'(dif.div_zero), W'(0));
      repeat (34) tick();

      // MDR from memory, then to OutPort
      dif.mem_data_in = 32'h1234_5678; dif.mdr_read = 1'b1; dif.mdr_in = 1'b1;
      tick();
      dif.mdr_in = 1'b0; dif.mdr_read = 1'b0;
      cmp("mdr_mem", dif.mdr, 32'h1234_5678);
      dif.bus_src = 4'd6; dif.outport_in = 1'b1;
      tick();
      dif.outport_in = 1'b0;
      cmp("outport", dif.outport, 32'h1234_5678);

      // Reset in the middle of a MUL run
      load_y(32'd5);
      dif.imm = 32'd6; dif.alu_op = 4'd11; dif.alu_start = 1'b1;
      tick();
      dif.alu_start = 1'b0;
      repeat (9) tick();
      clr = 1'b0;
      tick();
      cmp("rst_mid_busy", W'(dif.alu_busy), W'(0));
      cmp("rst_mid_done", W'(dif.alu_done), W'(0));
      cmp("rst_mid_zhi", dif.zhi, '0);
      cmp("rst_mid_zlo", dif.zlo, '0);
      cmp("rst_mid_pc", dif.pc, '0);
      cmp("rst_mid_mdr", dif.mdr, '0);
      clr = 1'b1;
      repeat (30) begin
         tick();
         cmp("rst_mid_nodone", W'(dif.alu_done), W'(0));
      end

      // Randomised traffic
      for (int n = 0; n < 3000; n++) begin
         logic [W-1:0] v;
         case ($urandom_range(0, 5))
            0: v = $urandom;
            1: v = W'($urandom_range(0, 9));
            2: v = -W'($urandom_range(1, 9));
            3: v = '0;
            4: v = 32'h8000_0000;
            default: v = '1;
         endcase
         dif.imm         = v;
         dif.bus_src     = 4'($urandom_range(0, 15));
         dif.rd_sel      = 4'($urandom);
         dif.wr_sel      = 4'($urandom);
         dif.rf_wr       = ($urandom % 4 == 0);
         dif.y_in        = ($urandom % 3 == 0);
         dif.hi_in       = ($urandom % 4 == 0);
         dif.lo_in       = ($urandom % 4 == 0);
         dif.ir_in       = ($urandom % 4 == 0);
         dif.mar_in      = ($urandom % 4 == 0);
         dif.outport_in  = ($urandom % 4 == 0);
         dif.pc_in       = ($urandom % 6 == 0);
         dif.pc_inc      = ($urandom % 3 == 0);
         dif.mdr_in      = ($urandom % 3 == 0);
         dif.mdr_read    = 1'($urandom);
         dif.z_in        = ($urandom % 3 == 0);
         dif.alu_op      = ($urandom % 3 == 0) ? 4'($urandom_range(11, 12)) : 4'($urandom);
         dif.alu_start   = ($urandom % 6 == 0);
         dif.mem_data_in = $urandom;
         dif.inport_data = $urandom;
         clr             = ($urandom % 400 == 0) ? 1'b0 : 1'b1;
         tick();
      end
      clr = 1'b1;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
